// File: rtl/stack_cpu_pkg.sv
// Shared constants for the stack CPU slice: memory arbiter state encoding,
// memory map and opcode values.
package stack_cpu_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    // Memory-mapped IO occupies the top eight bytes of the 256-byte space.
    localparam logic [7:0] MMIO_BASE = 8'hF8;
    localparam logic [7:0] MMIO_ERR  = 8'hFD;
    localparam logic [7:0] MMIO_IN   = 8'hFE;
    localparam logic [7:0] MMIO_OUT  = 8'hFF;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_LOAD  = 8'h05;
    localparam logic [7:0] OP_STORE = 8'h06;
    localparam logic [7:0] OP_JMP   = 8'h07;
    localparam logic [7:0] OP_JZ    = 8'h08;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    function automatic logic is_io_addr(input logic [7:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Counts consecutive accepted accesses of the current memory owner; saturates
// at HOLD_MAX so a lone requester can stream indefinitely.
module arb_hold_counter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == CNT_W'(HOLD_MAX));
    assign cnt    = cnt_q;

    // NOTE: clear has priority over increment so an ownership change that
    // coincides with an accepted access starts the new owner from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !at_max)
            cnt_d = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // logic lives in always_comb with a default first, so no latches appear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stack_mem_arbiter.sv
// Two-port round-robin arbiter for the single-port stack-CPU memory (port 0 = CPU,
// port 1 = loader/debug). Define STACK_MEM_ARB_IO_PROTECT_EN to block port-1 IO writes.
module stack_mem_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                HOLD_MAX = 4,
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(stack_cpu_pkg::MMIO_BASE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              prot_err
);

    import stack_cpu_pkg::*;

    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_tag_q, rd_tag_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              own_sel;
    logic              own_req, oth_req, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              acc_any;
    logic              hold_clr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              hold_at_max;
    logic              limit_hit;
    logic              io_wr1;
    logic              prot_blk;

    assign m0_gnt  = (state_q == ARB_OWN0);
    assign m1_gnt  = (state_q == ARB_OWN1);
    assign own_sel = (state_q == ARB_OWN1);

    always_comb begin
        own_req   = m0_req;
        oth_req   = m1_req;
        own_we    = m0_we;
        own_addr  = m0_addr;
        own_wdata = m0_wdata;
        if (own_sel) begin
            own_req   = m1_req;
            oth_req   = m0_req;
            own_we    = m1_we;
            own_addr  = m1_addr;
            own_wdata = m1_wdata;
        end
    end

    assign acc_any = own_req & (m0_gnt | m1_gnt);
    assign io_wr1  = m1_gnt & m1_req & m1_we & (m1_addr >= IO_BASE);

`ifdef STACK_MEM_ARB_IO_PROTECT_EN
    logic prot_err_q;

    assign prot_blk = io_wr1;
    assign prot_err = prot_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prot_err_q <= 1'b0;
        else
            prot_err_q <= prot_blk;
    end
`else
    logic unused_io_wr1;

    assign unused_io_wr1 = io_wr1;
    assign prot_blk      = 1'b0;
    assign prot_err      = 1'b0;
`endif

    // Blocked IO writes still complete the handshake but never reach memory.
    assign mem_en    = acc_any & ~prot_blk;
    assign mem_we    = mem_en & own_we;
    assign mem_addr  = own_addr;
    assign mem_wdata = own_wdata;

    arb_hold_counter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (hold_clr),
        .inc    (acc_any),
        .cnt    (hold_cnt),
        .at_max (hold_at_max)
    );

    // Evaluates hold_cnt + accept >= HOLD_MAX without widening the counter.
    assign limit_hit = hold_at_max | (acc_any & (hold_cnt == CNT_W'(HOLD_MAX - 1)));

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        hold_clr = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (m0_req && m1_req)
                    state_d = last_q ? ARB_OWN0 : ARB_OWN1;
                else if (m0_req)
                    state_d = ARB_OWN0;
                else if (m1_req)
                    state_d = ARB_OWN1;
            end
            ARB_OWN0, ARB_OWN1: begin
                if (oth_req && (!own_req || limit_hit)) begin
                    state_d  = own_sel ? ARB_OWN0 : ARB_OWN1;
                    last_d   = own_sel;
                    hold_clr = 1'b1;
                end else if (!own_req && !oth_req) begin
                    state_d  = ARB_IDLE;
                    last_d   = own_sel;
                    hold_clr = 1'b1;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                hold_clr = 1'b1;
            end
        endcase
    end

    // The tag remembers which port issued the read, so a same-edge owner switch
    // cannot misroute the returning data.
    assign rd_vld_d  = acc_any & ~own_we;
    assign rd_tag_d  = own_sel;
    assign m0_rvalid = rd_vld_q & ~rd_tag_q;
    assign m1_rvalid = rd_vld_q & rd_tag_q;
    assign rdata0_d  = m0_rvalid ? mem_rdata : rdata0_q;
    assign rdata1_d  = m1_rvalid ? mem_rdata : rdata1_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

    // NOTE: the read-data holding registers are reset like any other flop; they
    // are architectural outputs that must read 0 after reset, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            last_q   <= 1'b1;
            rd_vld_q <= 1'b0;
            rd_tag_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rd_vld_q <= rd_vld_d;
            rd_tag_q <= rd_tag_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
